// File: rtl/decoder_proj_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_proj_pkg
// Purpose  : Shared types and constants for the nibble decoder.
// Revision : 1.0
// ============================================================================
package decoder_proj_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_HEX    = 2'b01,
        MODE_BCD    = 2'b10,
        MODE_THERM  = 2'b11
    } mode_e;

    localparam int DATA_LSB = 0;
    localparam int DATA_MSB = 3;
    localparam int EN_BIT   = 4;
    localparam int MODE_LSB = 5;
    localparam int MODE_MSB = 6;

    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] THERM_FULL = 4'd8;

    // Segments {g,f,e,d,c,b,a}, active-high; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage : decoder_proj_pkg
`default_nettype wire

// File: rtl/decoder_proj_seg7.sv
`default_nettype none
// ============================================================================
// Module   : decoder_proj_seg7
// Purpose  : Combinational nibble to 7-segment lookup.
// Revision : 1.0
// ============================================================================
module decoder_proj_seg7
    import decoder_proj_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_TABLE[nib_i];

endmodule : decoder_proj_seg7
`default_nettype wire

// File: rtl/decoder_proj.sv
`default_nettype none
// ============================================================================
// Module   : decoder_proj
// Purpose  : Registered multi-mode nibble decoder (one-hot/hex/BCD/thermo).
//            DECODER_PROJ_FORMAL_EN compiles in assertions and cover points.
// Revision : 1.0
// ============================================================================
module decoder_proj
    import decoder_proj_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] io_in,
    output logic [7:0] io_out,
    output logic       err,
    output logic       valid
);

    logic [3:0] data_w;
    logic       en_w;
    mode_e      mode_w;
    logic [6:0] seg_w;

    logic [7:0] io_out_d, io_out_q;
    logic       err_d,    err_q;
    logic       valid_d,  valid_q;

    assign data_w = io_in[DATA_MSB:DATA_LSB];
    assign en_w   = io_in[EN_BIT];
    assign mode_w = mode_e'(io_in[MODE_MSB:MODE_LSB]);

    decoder_proj_seg7 u_seg7 (
        .nib_i (data_w),
        .seg_o (seg_w)
    );

    always_comb begin
        io_out_d = 8'h00;
        err_d    = 1'b0;
        valid_d  = en_w;
        if (en_w) begin
            case (mode_w)
                MODE_ONEHOT: begin
                    io_out_d = 8'h01 << data_w[2:0];
                    err_d    = data_w[3];
                end
                MODE_HEX: io_out_d = {1'b0, seg_w};
                MODE_BCD: begin
                    if (data_w <= BCD_MAX) io_out_d = {1'b0, seg_w};
                    else                   err_d    = 1'b1;
                end
                MODE_THERM: begin
                    // Any d >= 8 saturates to a full bar.
                    if (data_w[3]) io_out_d = 8'hFF;
                    else           io_out_d = (8'h01 << data_w[2:0]) - 8'h01;
                    err_d = (data_w > THERM_FULL);
                end
                default: io_out_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_out_q <= 8'h00;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            io_out_q <= io_out_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign io_out = io_out_q;
    assign err    = err_q;
    assign valid  = valid_q;

`ifdef DECODER_PROJ_FORMAL_EN
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && $past(mode_w == MODE_ONEHOT)) |-> $onehot(io_out_q));
    a_err_valid: assert property (@(posedge clk) disable iff (!rst_n)
        err_q |-> valid_q);
    a_idle_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !valid_q |-> (io_out_q == 8'h00));
    a_bcd_blank: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_q && $past(mode_w == MODE_BCD) && io_out_q == 8'h00) |-> err_q);

    c_onehot: cover property (@(posedge clk) en_w && mode_w == MODE_ONEHOT);
    c_hex:    cover property (@(posedge clk) en_w && mode_w == MODE_HEX);
    c_bcd:    cover property (@(posedge clk) en_w && mode_w == MODE_BCD);
    c_therm:  cover property (@(posedge clk) en_w && mode_w == MODE_THERM);
    c_bcd_12: cover property (@(posedge clk) en_w && mode_w == MODE_BCD && data_w == 4'd12);
`else
`endif

endmodule : decoder_proj
`default_nettype wire

// File: tb/tb_decoder_proj.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_proj
// Purpose  : Self-checking bench for decoder_proj against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_decoder_proj;

    logic       clk;
    logic       rst_n;
    logic [6:0] io_in;
    logic [7:0] io_out;
    logic       err;
    logic       valid;

    int vectors;
    int miscompares;

    decoder_proj dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_in  (io_in),
        .io_out (io_out),
        .err    (err),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {valid, err, io_out} expected one cycle after sampling v.
    function automatic logic [9:0] ref_model(input logic [6:0] v);
        int seg [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                         'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
        int d, m, o, n;
        logic e;
        d = int'(v[3:0]);
        m = int'(v[6:5]);
        o = 0;
        e = 1'b0;
        if (v[4] == 1'b0) return 10'h000;
        case (m)
            0: begin o = 1 << (d % 8); e = (d >= 8); end
            1: o = seg[d];
            2: begin
                if (d <= 9) o = seg[d];
                else begin o = 0; e = 1'b1; end
            end
            default: begin
                n = (d > 8) ? 8 : d;
                o = (1 << n) - 1;
                e = (d > 8);
            end
        endcase
        return {1'b1, e, o[7:0]};
    endfunction

    task automatic step(input logic [6:0] v);
        @(negedge clk);
        io_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        io_in = 7'b0011111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({valid, err, io_out} !== 10'h000) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got v=%b e=%b o=%h want 0/0/00", i, valid, err, io_out);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bcd_oor;
        step(7'b1011100);
        vectors++;
        if ({valid, err, io_out} !== {1'b1, 1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL bcd_oor got v=%b e=%b o=%h want 1/1/00", valid, err, io_out);
        end
    endtask

    task automatic test_onehot;
        logic [9:0] prev_exp, exp_v;
        logic [6:0] v;
        prev_exp = {valid, err, io_out};
        for (int d = 0; d < 16; d++) begin
            v = {2'b00, 1'b1, 4'(d)};
            exp_v = ref_model(v);
            @(negedge clk);
            io_in = v;
            #1;
            vectors++;
            if ({valid, err, io_out} !== prev_exp) begin
                miscompares++;
                $display("FAIL onehot_latency d=%0d got %h want %h", d, {valid, err, io_out}, prev_exp);
            end
            @(posedge clk);
            #1;
            vectors++;
            if ({valid, err, io_out} !== exp_v) begin
                miscompares++;
                $display("FAIL onehot d=%0d got %h want %h", d, {valid, err, io_out}, exp_v);
            end
            prev_exp = exp_v;
        end
    endtask

    task automatic test_hex;
        logic [3:0] ds [4] = '{4'h0, 4'h9, 4'hA, 4'hF};
        logic [7:0] want [4] = '{8'h3F, 8'h6F, 8'h77, 8'h71};
        for (int i = 0; i < 4; i++) begin
            step({2'b01, 1'b1, ds[i]});
            vectors++;
            if ({valid, err, io_out} !== {1'b1, 1'b0, want[i]}) begin
                miscompares++;
                $display("FAIL hex d=%h got v=%b e=%b o=%h want 1/0/%h", ds[i], valid, err, io_out, want[i]);
            end
        end
    endtask

    task automatic test_therm;
        logic [3:0] ds [4] = '{4'd0, 4'd3, 4'd8, 4'd13};
        logic [7:0] want [4] = '{8'h00, 8'h07, 8'hFF, 8'hFF};
        logic       we   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step({2'b11, 1'b1, ds[i]});
            vectors++;
            if ({valid, err, io_out} !== {1'b1, we[i], want[i]}) begin
                miscompares++;
                $display("FAIL therm d=%0d got v=%b e=%b o=%h want 1/%b/%h", ds[i], valid, err, io_out, we[i], want[i]);
            end
        end
    endtask

    task automatic test_disable;
        step(7'b0110101);
        vectors++;
        if ({valid, err, io_out} !== {1'b1, 1'b0, 8'h6D}) begin
            miscompares++;
            $display("FAIL disable_c1 got v=%b e=%b o=%h want 1/0/6d", valid, err, io_out);
        end
        step(7'b0100101);
        vectors++;
        if ({valid, err, io_out} !== 10'h000) begin
            miscompares++;
            $display("FAIL disable_c2 got v=%b e=%b o=%h want 0/0/00", valid, err, io_out);
        end
    endtask

    task automatic test_async_reset;
        step(7'b1111111);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({valid, err, io_out} !== 10'h000) begin
            miscompares++;
            $display("FAIL async_reset got v=%b e=%b o=%h want 0/0/00", valid, err, io_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        io_in = 7'b1110011;
        @(posedge clk);
        #1;
        vectors++;
        if ({valid, err, io_out} !== {1'b1, 1'b0, 8'h07}) begin
            miscompares++;
            $display("FAIL post_reset got v=%b e=%b o=%h want 1/0/07", valid, err, io_out);
        end
    endtask

    task automatic test_random;
        logic [6:0] v;
        logic [9:0] exp_v;
        for (int i = 0; i < 300; i++) begin
            v = 7'($urandom);
            exp_v = ref_model(v);
            step(v);
            vectors++;
            if ({valid, err, io_out} !== exp_v) begin
                miscompares++;
                $display("FAIL random i=%0d in=%b got %h want %h", i, v, {valid, err, io_out}, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        io_in       = 7'h00;
        test_reset();
        test_bcd_oor();
        test_onehot();
        test_hex();
        test_therm();
        test_disable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_decoder_proj
`default_nettype wire
